// File: rtl/pci_master_32.sv
// Single-channel 32-bit burst initiator for the shared target bus: fetches write
// words from a local source or returns read words to a local sink, one bus word at a time.
module pci_master_32 #(
    parameter int TIMEOUT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        cmd_write,
    input  logic [31:0] start_add,
    input  logic [4:0]  burst_len,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_be,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        busy,
    output logic        done,
    output logic        abort,
    output logic        truncated,
    output logic [4:0]  xfer_cnt,
    output logic [31:0] add_out,
    output logic [31:0] data_out,
    output logic [3:0]  be,
    output logic        we,
    output logic        req_64,
    input  logic        devsel_n,
    input  logic        last_add,
    input  logic [31:0] data_in
);

    typedef enum logic [2:0] {IDLE, FETCH, DRIVE, CHECK, END} state_t;

    localparam logic [3:0]  WAIT_LAST = 4'(TIMEOUT - 1);
    localparam logic [31:0] ADD_TOP   = 32'hFFFF_FFFC;

    state_t      state;
    logic        is_write;
    logic [4:0]  remaining;
    logic [3:0]  wait_cnt;
    logic        trunc_r;
    logic        unused_add_lsbs;

    function automatic logic [4:0] norm_len(input logic [4:0] len);
        return (len == 5'd0) ? 5'd1 : len;
    endfunction

    assign req_64          = 1'b0;
    assign unused_add_lsbs = ^start_add[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            is_write  <= 1'b0;
            remaining <= 5'd0;
            wait_cnt  <= 4'd0;
            trunc_r   <= 1'b0;
            wr_ready  <= 1'b0;
            rd_data   <= 32'd0;
            rd_valid  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            abort     <= 1'b0;
            truncated <= 1'b0;
            xfer_cnt  <= 5'd0;
            add_out   <= 32'd0;
            data_out  <= 32'd0;
            be        <= 4'd0;
            we        <= 1'b0;
        end else begin
            done      <= 1'b0;
            abort     <= 1'b0;
            truncated <= 1'b0;
            rd_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        is_write  <= cmd_write;
                        add_out   <= {start_add[31:2], 2'b00};
                        remaining <= norm_len(burst_len);
                        xfer_cnt  <= 5'd0;
                        trunc_r   <= 1'b0;
                        busy      <= 1'b1;
                        we        <= 1'b0;
                        if (cmd_write) begin
                            wr_ready <= 1'b1;
                            state    <= FETCH;
                        end else begin
                            be    <= 4'hF;
                            state <= DRIVE;
                        end
                    end
                end
                FETCH: begin
                    if (wr_valid) begin
                        data_out <= wr_data;
                        be       <= wr_be;
                        wr_ready <= 1'b0;
                        we       <= 1'b1;
                        state    <= DRIVE;
                    end
                end
                DRIVE: begin
                    we       <= 1'b0;
                    wait_cnt <= 4'd0;
                    state    <= CHECK;
                end
                CHECK: begin
                    if (!devsel_n) begin
                        xfer_cnt <= xfer_cnt + 5'd1;
                        if (!is_write) begin
                            rd_data  <= data_in;
                            rd_valid <= 1'b1;
                        end
                        if (remaining == 5'd1) begin
                            trunc_r <= 1'b0;
                            state   <= END;
                        end else if (last_add || add_out == ADD_TOP) begin
                            // target disconnect, or the next word would wrap past the top of the space
                            trunc_r <= 1'b1;
                            state   <= END;
                        end else begin
                            add_out   <= add_out + 32'd4;
                            remaining <= remaining - 5'd1;
                            if (is_write) begin
                                wr_ready <= 1'b1;
                                state    <= FETCH;
                            end else begin
                                state <= DRIVE;
                            end
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        abort <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                END: begin
                    done      <= 1'b1;
                    truncated <= trunc_r;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
